// File: rtl/password_matcher.sv
// Brute-force candidate matcher: loads a LENGTH-character target and stops on the first exact match.
// Optional attempt counter and port enabled by defining PASSWORD_MATCHER_ATTEMPTS_EN.
//
//   state     | meaning
//   IDLE      | loading target characters, waiting for start
//   SEARCH    | accepting candidates and comparing against target
//   FOUND     | match located, match_word held
//   EXHAUSTED | final candidate seen without a match
module password_matcher #(
  parameter int LENGTH      = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load_valid,
  input  logic [7:0]            load_char,
  input  logic                  start,
  input  logic                  cand_valid,
  input  logic [8*LENGTH-1:0]   cand_word,
  input  logic                  cand_last,
  output logic                  cand_ready,
  output logic                  busy,
  output logic                  found,
  output logic                  not_found,
`ifdef PASSWORD_MATCHER_ATTEMPTS_EN
  output logic [8*LENGTH-1:0]   match_word,
  output logic [COUNT_WIDTH-1:0] attempts
`else
  output logic [8*LENGTH-1:0]   match_word
`endif
);

  localparam int IDX_W = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEARCH    = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [8*LENGTH-1:0] target;
  logic [IDX_W-1:0]    load_idx;
  logic                target_loaded;
  logic                accept;
  logic                hit;
  logic                go;

  assign target_loaded = (load_idx == IDX_W'(LENGTH));
  assign accept        = (state_q == SEARCH) && cand_valid;
  assign hit           = accept && (cand_word == target);
  // start is honoured from IDLE only once the full target is in place
  assign go            = start && (((state_q == IDLE) && target_loaded) ||
                                   (state_q == FOUND) || (state_q == EXHAUSTED));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (go) begin
      state_d = SEARCH;
    end else if (accept) begin
      if (hit)            state_d = FOUND;
      else if (cand_last) state_d = EXHAUSTED;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target     <= '0;
      load_idx   <= '0;
      match_word <= '0;
    end else if (clear) begin
      target     <= '0;
      load_idx   <= '0;
      match_word <= '0;
    end else begin
      if (go)       match_word <= '0;
      else if (hit) match_word <= cand_word;
      if ((state_q == IDLE) && load_valid && !target_loaded) begin
        for (int i = 0; i < LENGTH; i++) begin
          if (load_idx == IDX_W'(i)) target[8*i +: 8] <= load_char;
        end
        load_idx <= load_idx + IDX_W'(1);
      end
    end
  end

`ifdef PASSWORD_MATCHER_ATTEMPTS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          attempts <= '0;
    else if (clear || go)               attempts <= '0;
    else if (accept && (attempts != '1)) attempts <= attempts + COUNT_WIDTH'(1);
  end
`endif

  assign cand_ready = (state_q == SEARCH);
  assign busy       = (state_q == SEARCH);
  assign found      = (state_q == FOUND);
  assign not_found  = (state_q == EXHAUSTED);

endmodule

// File: tb/tb_password_matcher.sv
// Self-checking bench for password_matcher (LENGTH=4) against a behavioural model.
// Attempt-count checks are active when PASSWORD_MATCHER_ATTEMPTS_EN is defined.
module tb_password_matcher;

  localparam int L = 4;

  logic          clock = 0;
  logic          reset, clear, load_valid, start, cand_valid, cand_last;
  logic [7:0]    load_char;
  logic [8*L-1:0] cand_word;
  logic          cand_ready, busy, found, not_found;
  logic [8*L-1:0] match_word;
`ifdef PASSWORD_MATCHER_ATTEMPTS_EN
  logic [31:0]   attempts;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam int M_IDLE = 0, M_SEARCH = 1, M_FOUND = 2, M_EXH = 3;
  int            m_mode;
  int            m_nloaded;
  logic [7:0]    m_tgt [L];
  logic [8*L-1:0] m_match;
  logic [31:0]   m_att;

  password_matcher #(.LENGTH(L), .COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .load_valid(load_valid), .load_char(load_char), .start(start),
    .cand_valid(cand_valid), .cand_word(cand_word), .cand_last(cand_last),
    .cand_ready(cand_ready), .busy(busy), .found(found), .not_found(not_found),
`ifdef PASSWORD_MATCHER_ATTEMPTS_EN
    .match_word(match_word), .attempts(attempts)
`else
    .match_word(match_word)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [8*L-1:0] mk_word(string s);
    logic [8*L-1:0] w;
    for (int i = 0; i < L; i++) w[8*i +: 8] = s[i];
    return w;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_nloaded = 0; m_match = '0; m_att = 0;
    for (int i = 0; i < L; i++) m_tgt[i] = 8'h00;
  endtask

  // One clock edge of the reference behaviour, using the currently driven inputs.
  task automatic model_edge();
    logic eq;
    if (reset || clear) begin
      model_reset();
    end else if (start && ((m_mode == M_IDLE && m_nloaded == L) || m_mode == M_FOUND || m_mode == M_EXH)) begin
      m_mode = M_SEARCH; m_match = '0; m_att = 0;
    end else begin
      if (m_mode == M_IDLE && load_valid && m_nloaded < L) begin
        m_tgt[m_nloaded] = load_char;
        m_nloaded++;
      end
      if (m_mode == M_SEARCH && cand_valid) begin
        if (m_att != 32'hFFFF_FFFF) m_att++;
        eq = 1'b1;
        for (int i = 0; i < L; i++) if (cand_word[8*i +: 8] != m_tgt[i]) eq = 1'b0;
        if (eq) begin
          m_match = cand_word; m_mode = M_FOUND;
        end else if (cand_last) begin
          m_mode = M_EXH;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0; load_valid = 0; load_char = 0; start = 0;
    cand_valid = 0; cand_word = '0; cand_last = 0;
  endtask

  task automatic load_str(string s, int n);
    for (int i = 0; i < n; i++) begin
      load_valid = 1; load_char = s[i];
      tick();
    end
    load_valid = 0;
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    model_reset();
    #12;
    n_checks++;
    if ({cand_ready, busy, found, not_found} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_flags got=%b want=0000", {cand_ready, busy, found, not_found});
    end
    n_checks++;
    if (match_word !== '0) begin
      n_errors++; $display("FAIL reset_match got=%h want=0", match_word);
    end
`ifdef PASSWORD_MATCHER_ATTEMPTS_EN
    n_checks++;
    if (attempts !== 32'd0) begin
      n_errors++; $display("FAIL reset_attempts got=%0d want=0", attempts);
    end
`endif
    @(posedge clock); #1;
    reset = 0;
    tick();
  endtask

  task automatic test_match();
    string seq [3] = '{"aaaa", "abca", "abcd"};
    do_clear();
    load_str("abcd", 4);
    start = 1; tick(); start = 0;
    n_checks++;
    if (cand_ready !== 1'b1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL match_busy got=%b%b want=11", cand_ready, busy);
    end
    for (int k = 0; k < 3; k++) begin
      cand_valid = 1; cand_word = mk_word(seq[k]);
      tick();
      n_checks++;
      if (found !== (k == 2)) begin
        n_errors++; $display("FAIL match_found_k%0d got=%b want=%b", k, found, (k == 2));
      end
    end
    cand_valid = 0;
    n_checks++;
    if (match_word !== mk_word("abcd")) begin
      n_errors++; $display("FAIL match_word got=%h want=%h", match_word, mk_word("abcd"));
    end
    n_checks++;
    if (cand_ready !== 1'b0 || not_found !== 1'b0) begin
      n_errors++; $display("FAIL match_ready got=%b nf=%b want=0,0", cand_ready, not_found);
    end
`ifdef PASSWORD_MATCHER_ATTEMPTS_EN
    n_checks++;
    if (attempts !== 32'd3) begin
      n_errors++; $display("FAIL match_attempts got=%0d want=3", attempts);
    end
`endif
    tick(); tick();
    n_checks++;
    if (found !== 1'b1 || match_word !== mk_word("abcd")) begin
      n_errors++; $display("FAIL match_hold got=%b/%h want=1/%h", found, match_word, mk_word("abcd"));
    end
  endtask

  task automatic test_exhaust();
    do_clear();
    load_str("zzzz", 4);
    start = 1; tick(); start = 0;
    for (int k = 0; k < 26; k++) begin
      cand_valid = 1;
      cand_word = mk_word("aaaa");
      cand_word[31:24] = 8'h61 + 8'(k);
      cand_last = (k == 25);
      tick();
    end
    cand_valid = 0; cand_last = 0;
    n_checks++;
    if (not_found !== 1'b1 || found !== 1'b0) begin
      n_errors++; $display("FAIL exh_flags got nf=%b f=%b want nf=1 f=0", not_found, found);
    end
    n_checks++;
    if (match_word !== '0 || cand_ready !== 1'b0) begin
      n_errors++; $display("FAIL exh_word got=%h rdy=%b want=0,0", match_word, cand_ready);
    end
`ifdef PASSWORD_MATCHER_ATTEMPTS_EN
    n_checks++;
    if (attempts !== 32'd26) begin
      n_errors++; $display("FAIL exh_attempts got=%0d want=26", attempts);
    end
`endif
    // restart from EXHAUSTED keeps the target
    start = 1; tick(); start = 0;
    n_checks++;
    if (busy !== 1'b1 || not_found !== 1'b0) begin
      n_errors++; $display("FAIL exh_restart got busy=%b nf=%b want 1,0", busy, not_found);
    end
    cand_valid = 1; cand_word = mk_word("zzzz"); tick(); cand_valid = 0;
    n_checks++;
    if (found !== 1'b1) begin
      n_errors++; $display("FAIL exh_target_kept got=%b want=1", found);
    end
  endtask

  task automatic test_match_last();
    do_clear();
    load_str("abcd", 4);
    start = 1; tick(); start = 0;
    cand_valid = 1; cand_word = mk_word("abcd"); cand_last = 1;
    tick();
    cand_valid = 0; cand_last = 0;
    n_checks++;
    if (found !== 1'b1 || not_found !== 1'b0) begin
      n_errors++; $display("FAIL last_match got f=%b nf=%b want 1,0", found, not_found);
    end
  endtask

  task automatic test_partial_load();
    do_clear();
    load_str("wxyz", 3);
    start = 1; tick(); start = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL partial_start got=%b want=0", busy);
    end
    load_str("z", 1);
    start = 1; tick(); start = 0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++; $display("FAIL full_start got=%b want=1", busy);
    end
    cand_valid = 1; cand_word = mk_word("wxyz"); tick(); cand_valid = 0;
    n_checks++;
    if (found !== 1'b1 || match_word !== mk_word("wxyz")) begin
      n_errors++; $display("FAIL partial_match got=%b/%h want=1/%h", found, match_word, mk_word("wxyz"));
    end
  endtask

  task automatic test_clear_start();
    do_clear();
    load_str("abcd", 4);
    start = 1; tick(); start = 0;
    clear = 1; start = 1; tick(); clear = 0; start = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL clear_start got=%b want=0", busy);
    end
    start = 1; tick(); start = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL clear_target_lost got=%b want=0", busy);
    end
    load_str("dcba", 4);
    start = 1; tick(); start = 0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++; $display("FAIL clear_reload got=%b want=1", busy);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    load_str("abcd", 4);
    start = 1; tick(); start = 0;
    cand_valid = 1; cand_word = mk_word("bbbb"); tick();
    #2 reset = 1;
    #1;
    n_checks++;
    if ({cand_ready, busy, found, not_found, match_word} !== '0) begin
      n_errors++; $display("FAIL async_reset got=%b%b%b%b/%h want=0", cand_ready, busy, found, not_found, match_word);
    end
    cand_valid = 0;
    tick();
    reset = 0;
    start = 1; tick(); start = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_target_lost got=%b want=0", busy);
    end
  endtask

  task automatic test_random();
    logic [8*L-1:0] w;
    do_clear();
    for (int c = 0; c < 600; c++) begin
      clear      = ($urandom_range(63) == 0);
      start      = ($urandom_range(7) == 0);
      load_valid = $urandom_range(1);
      load_char  = 8'h61 + 8'($urandom_range(2));
      cand_valid = $urandom_range(1);
      for (int i = 0; i < L; i++) w[8*i +: 8] = 8'h61 + 8'($urandom_range(2));
      cand_word  = w;
      cand_last  = ($urandom_range(15) == 0);
      tick();
      n_checks++;
      if ({cand_ready, busy, found, not_found, match_word} !==
          {m_mode == M_SEARCH, m_mode == M_SEARCH, m_mode == M_FOUND, m_mode == M_EXH, m_match}) begin
        n_errors++;
        $display("FAIL random_c%0d got=%b%b%b%b/%h want mode=%0d match=%h",
                 c, cand_ready, busy, found, not_found, match_word, m_mode, m_match);
      end
`ifdef PASSWORD_MATCHER_ATTEMPTS_EN
      n_checks++;
      if (attempts !== m_att) begin
        n_errors++; $display("FAIL random_att_c%0d got=%0d want=%0d", c, attempts, m_att);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_match();
    test_exhaust();
    test_match_last();
    test_partial_load();
    test_clear_start();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
